// File: rtl/regbank_core.sv
// Register file, REG_COUNT x REG_WIDTH, one write port and two read ports, cleared by a sequencer after reset.
// Latency: reads are combinational with 0 cycles; a write is visible from storage one cycle after its edge.
// Backpressure: none on reads; while busy is high the CPU must stall, writes are ignored and reads return 0.
module regbank_core #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned REG_COUNT = 16,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1,
  localparam int unsigned AW       = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [REG_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr1,
  input  logic [AW-1:0]        raddr2,
  output logic [REG_WIDTH-1:0] rdata1,
  output logic [REG_WIDTH-1:0] rdata2,
  output logic                 busy
);

  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_clr_cnt;
  logic [AW-1:0]        w_clr_cnt_nxt;
  logic                 w_clr_last;

  // Storage carries no reset so it can map onto a plain RAM macro; the
  // clear sequencer is what gives it defined contents.
  logic [REG_WIDTH-1:0] r_mem [REG_COUNT];

  logic                 w_wr_drop;
  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_addr;
  logic [REG_WIDTH-1:0] w_mem_dat;

  assign busy       = (r_state == ST_CLEAR);
  assign w_clr_last = (r_clr_cnt == AW'(REG_COUNT - 1));

  // A write to R0 is discarded when R0 is hardwired to zero.
  assign w_wr_drop  = ZERO_EN && (waddr == '0);

  // The sequencer owns the write port while clearing; a CPU write during that
  // time is simply ignored, never queued. rst itself leaves storage alone.
  assign w_mem_we   = !rst && (busy || (we && !w_wr_drop));
  assign w_mem_addr = busy ? r_clr_cnt : waddr;
  assign w_mem_dat  = busy ? '0 : wdata;

  // State register and clear counter; rst always restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: step through every entry once, then hand over to the CPU.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (w_clr_last) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // Single shared write port into storage (clear zeros or CPU data).
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_dat;
    end
  end

  // Read port 1: hardwired zero beats the bypass, the bypass beats storage.
  always_comb begin
    rdata1 = r_mem[raddr1];
    if (busy) begin
      rdata1 = '0;
    end else if (ZERO_EN && (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (BYP_EN && we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    rdata2 = r_mem[raddr2];
    if (busy) begin
      rdata2 = '0;
    end else if (ZERO_EN && (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (BYP_EN && we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule
